// File: rtl/bp_cfg_loader_if.sv
// Config-link and microcode-ROM signals between the cfg loader (master) and the
// tile array / ROM side (slave).
interface bp_cfg_loader_if #(
  parameter int num_core_p       = 1,
  parameter int cce_pc_width_p   = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64
);
  localparam int lg_num_core_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

  logic                        cfg_v_o;
  logic                        cfg_ready_i;
  logic [lg_num_core_lp-1:0]   cfg_core_o;
  logic [cfg_addr_width_p-1:0] cfg_addr_o;
  logic [cfg_data_width_p-1:0] cfg_data_o;

  logic                        ucode_v_o;
  logic [cce_pc_width_p-1:0]   ucode_addr_o;
  logic [cfg_data_width_p-1:0] ucode_data_i;

  modport master (
    output cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o, ucode_v_o, ucode_addr_o,
    input  cfg_ready_i, ucode_data_i
  );

  modport slave (
    input  cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o, ucode_v_o, ucode_addr_o,
    output cfg_ready_i, ucode_data_i
  );
endinterface

// File: rtl/bp_cfg_loader.sv
// Post-reset configuration sequencer: freezes each core, writes its id and CCE mode,
// optionally streams CCE microcode from a ROM, then unfreezes every core.
module bp_cfg_loader #(
  parameter int num_core_p       = 1,
  parameter int cce_pc_width_p   = 8,
  parameter int ucode_els_p      = 256,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             cce_mode_i,
  input  logic             ucode_en_i,
  bp_cfg_loader_if.master  bus,
  output logic             busy_o,
  output logic             done_o
);
  localparam int lg_num_core_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

  localparam logic [cfg_addr_width_p-1:0] addr_freeze_lp   = cfg_addr_width_p'(16'h0001);
  localparam logic [cfg_addr_width_p-1:0] addr_core_id_lp  = cfg_addr_width_p'(16'h0002);
  localparam logic [cfg_addr_width_p-1:0] addr_cce_mode_lp = cfg_addr_width_p'(16'h0003);
  localparam logic [cfg_addr_width_p-1:0] addr_ucode_lp    = cfg_addr_width_p'(16'h8000);

  localparam logic [lg_num_core_lp-1:0] last_core_lp = lg_num_core_lp'(num_core_p - 1);
  localparam logic [cce_pc_width_p-1:0] last_word_lp = cce_pc_width_p'(ucode_els_p - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_UC_REQ, S_UC_SEND, S_UNFRZ, S_DONE
  } state_e;

  state_e                      state_r, state_n;
  logic [lg_num_core_lp-1:0]   core_r, core_n;
  logic [1:0]                  step_r, step_n;
  logic [cce_pc_width_p-1:0]   word_r, word_n;
  logic                        mode_r, mode_n;
  logic                        en_r, en_n;
  logic [cfg_data_width_p-1:0] hold_r, hold_n;
  logic                        hold_vld_r, hold_vld_n;

  logic                        cfg_v;
  logic [lg_num_core_lp-1:0]   cfg_core;
  logic [cfg_addr_width_p-1:0] cfg_addr;
  logic [cfg_data_width_p-1:0] cfg_data;
  logic                        ucode_v;
  logic [cce_pc_width_p-1:0]   ucode_addr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= S_IDLE;
      core_r     <= '0;
      step_r     <= '0;
      word_r     <= '0;
      mode_r     <= 1'b0;
      en_r       <= 1'b0;
      hold_r     <= '0;
      hold_vld_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      core_r     <= core_n;
      step_r     <= step_n;
      word_r     <= word_n;
      mode_r     <= mode_n;
      en_r       <= en_n;
      hold_r     <= hold_n;
      hold_vld_r <= hold_vld_n;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state_r;
    core_n     = core_r;
    step_n     = step_r;
    word_n     = word_r;
    mode_n     = mode_r;
    en_n       = en_r;
    hold_n     = hold_r;
    hold_vld_n = hold_vld_r;
    cfg_v      = 1'b0;
    cfg_core   = '0;
    cfg_addr   = '0;
    cfg_data   = '0;
    ucode_v    = 1'b0;
    ucode_addr = '0;

    unique case (state_r)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          mode_n     = cce_mode_i;
          en_n       = ucode_en_i;
          core_n     = '0;
          step_n     = '0;
          word_n     = '0;
          hold_vld_n = 1'b0;
          state_n    = S_CFG;
        end
      end

      S_CFG: begin
        cfg_v    = 1'b1;
        cfg_core = core_r;
        unique case (step_r)
          2'd0: begin
            cfg_addr = addr_freeze_lp;
            cfg_data = cfg_data_width_p'(1);
          end
          2'd1: begin
            cfg_addr = addr_core_id_lp;
            cfg_data = cfg_data_width_p'(core_r);
          end
          default: begin
            cfg_addr = addr_cce_mode_lp;
            cfg_data = cfg_data_width_p'(mode_r);
          end
        endcase
        if (bus.cfg_ready_i) begin
          if (step_r == 2'd2) begin
            step_n = '0;
            if (core_r == last_core_lp) begin
              core_n  = '0;
              word_n  = '0;
              state_n = en_r ? S_UC_REQ : S_UNFRZ;
            end else begin
              core_n = core_r + 1'b1;
            end
          end else begin
            step_n = step_r + 1'b1;
          end
        end
      end

      S_UC_REQ: begin
        ucode_v    = 1'b1;
        ucode_addr = word_r;
        hold_vld_n = 1'b0;
        state_n    = S_UC_SEND;
      end

      S_UC_SEND: begin
        // ROM data is only valid the cycle after the request; the hold register
        // keeps the packet stable for however long the link stalls.
        if (!hold_vld_r) begin
          hold_n     = bus.ucode_data_i;
          hold_vld_n = 1'b1;
        end else begin
          cfg_v    = 1'b1;
          cfg_core = core_r;
          cfg_addr = addr_ucode_lp + cfg_addr_width_p'(word_r);
          cfg_data = hold_r;
          if (bus.cfg_ready_i) begin
            hold_vld_n = 1'b0;
            state_n    = S_UC_REQ;
            if (word_r == last_word_lp) begin
              word_n = '0;
              if (core_r == last_core_lp) begin
                core_n  = '0;
                state_n = S_UNFRZ;
              end else begin
                core_n = core_r + 1'b1;
              end
            end else begin
              word_n = word_r + 1'b1;
            end
          end
        end
      end

      S_UNFRZ: begin
        cfg_v    = 1'b1;
        cfg_core = core_r;
        cfg_addr = addr_freeze_lp;
        cfg_data = '0;
        if (bus.cfg_ready_i) begin
          if (core_r == last_core_lp) begin
            core_n  = '0;
            state_n = S_DONE;
          end else begin
            core_n = core_r + 1'b1;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign bus.cfg_v_o      = cfg_v;
  assign bus.cfg_core_o   = cfg_core;
  assign bus.cfg_addr_o   = cfg_addr;
  assign bus.cfg_data_o   = cfg_data;
  assign bus.ucode_v_o    = ucode_v;
  assign bus.ucode_addr_o = ucode_addr;

  assign busy_o = (state_r == S_CFG) || (state_r == S_UC_REQ) ||
                  (state_r == S_UC_SEND) || (state_r == S_UNFRZ);
  assign done_o = (state_r == S_DONE);
endmodule

// File: tb/tb_bp_cfg_loader.sv
// Bench for bp_cfg_loader: three instances (1 core, 4 cores, 2 cores with microcode)
// checked against an expected-packet queue built from the sequence definition.
module tb_bp_cfg_loader;
  localparam int aw = 16;
  localparam int dw = 64;
  localparam int pw = 8;

  typedef struct {
    int          core;
    int          addr;
    logic [63:0] data;
  } pkt_t;

  pkt_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // Instance A: 1 core, no microcode
  logic start_a = 0, mode_a = 0, en_a = 0, rdy_a = 0, busy_a, done_a;
  bp_cfg_loader_if #(.num_core_p(1), .cce_pc_width_p(pw), .cfg_addr_width_p(aw),
                     .cfg_data_width_p(dw)) if_a ();
  assign if_a.cfg_ready_i  = rdy_a;
  assign if_a.ucode_data_i = '0;
  bp_cfg_loader #(.num_core_p(1), .cce_pc_width_p(pw), .ucode_els_p(4),
                  .cfg_addr_width_p(aw), .cfg_data_width_p(dw)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_a), .cce_mode_i(mode_a),
    .ucode_en_i(en_a), .bus(if_a.master), .busy_o(busy_a), .done_o(done_a));

  // Instance B: 4 cores, no microcode
  logic start_b = 0, mode_b = 0, en_b = 0, rdy_b = 0, busy_b, done_b;
  bp_cfg_loader_if #(.num_core_p(4), .cce_pc_width_p(pw), .cfg_addr_width_p(aw),
                     .cfg_data_width_p(dw)) if_b ();
  assign if_b.cfg_ready_i  = rdy_b;
  assign if_b.ucode_data_i = '0;
  bp_cfg_loader #(.num_core_p(4), .cce_pc_width_p(pw), .ucode_els_p(4),
                  .cfg_addr_width_p(aw), .cfg_data_width_p(dw)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_b), .cce_mode_i(mode_b),
    .ucode_en_i(en_b), .bus(if_b.master), .busy_o(busy_b), .done_o(done_b));

  // Instance C: 2 cores, 4 microcode words, ROM word = addr*0x11, garbage when not read
  logic start_c = 0, mode_c = 0, en_c = 0, rdy_c = 0, busy_c, done_c;
  logic [63:0] rom_c = '0;
  bp_cfg_loader_if #(.num_core_p(2), .cce_pc_width_p(pw), .cfg_addr_width_p(aw),
                     .cfg_data_width_p(dw)) if_c ();
  assign if_c.cfg_ready_i  = rdy_c;
  assign if_c.ucode_data_i = rom_c;
  always @(posedge clk)
    rom_c <= if_c.ucode_v_o ? 64'(if_c.ucode_addr_o) * 64'h11 : 64'hDEAD_BEEF_0BAD_F00D;
  bp_cfg_loader #(.num_core_p(2), .cce_pc_width_p(pw), .ucode_els_p(4),
                  .cfg_addr_width_p(aw), .cfg_data_width_p(dw)) dut_c (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_c), .cce_mode_i(mode_c),
    .ucode_en_i(en_c), .bus(if_c.master), .busy_o(busy_c), .done_o(done_c));

  task automatic push_seq(input int n, input int els, input logic mode, input logic en);
    pkt_t p;
    for (int c = 0; c < n; c++) begin
      p.core = c; p.addr = 1; p.data = 64'd1;        exp_q.push_back(p);
      p.core = c; p.addr = 2; p.data = 64'(c);       exp_q.push_back(p);
      p.core = c; p.addr = 3; p.data = {63'd0, mode}; exp_q.push_back(p);
    end
    if (en)
      for (int c = 0; c < n; c++)
        for (int w = 0; w < els; w++) begin
          p.core = c; p.addr = 32'h8000 + w; p.data = 64'(w * 32'h11);
          exp_q.push_back(p);
        end
    for (int c = 0; c < n; c++) begin
      p.core = c; p.addr = 1; p.data = 64'd0; exp_q.push_back(p);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (if_a.cfg_v_o !== 1'b0 || if_a.cfg_addr_o !== '0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_a: v=%b addr=%h busy=%b done=%b, want all 0",
               if_a.cfg_v_o, if_a.cfg_addr_o, busy_a, done_a);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (if_b.cfg_v_o !== 1'b0 || if_b.cfg_data_o !== '0 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_b_idle: v=%b data=%h busy=%b done=%b, want all 0",
               if_b.cfg_v_o, if_b.cfg_data_o, busy_b, done_b);
    end
    total++;
    if (if_c.ucode_v_o !== 1'b0 || if_c.ucode_addr_o !== '0 || if_c.cfg_core_o !== '0 || done_c !== 1'b0) begin
      bad++;
      $display("FAIL reset_c_idle: ucode_v=%b ucode_addr=%h core=%h done=%b, want all 0",
               if_c.ucode_v_o, if_c.ucode_addr_o, if_c.cfg_core_o, done_c);
    end
  endtask

  task automatic test_single_core_latency();
    pkt_t p;
    exp_q.delete();
    push_seq(1, 4, 1'b1, 1'b0);
    mode_a = 1'b1; en_a = 1'b0; rdy_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      p = exp_q.pop_front();
      total++;
      if (if_a.cfg_v_o !== 1'b1 || if_a.cfg_core_o !== 1'(p.core) || if_a.cfg_addr_o !== 16'(p.addr) ||
          if_a.cfg_data_o !== p.data || busy_a !== 1'b1 || done_a !== 1'b0) begin
        bad++;
        $display("FAIL single_pkt%0d: v=%b core=%0d addr=%h data=%h busy=%b done=%b, want v=1 core=%0d addr=%h data=%h busy=1 done=0",
                 k, if_a.cfg_v_o, if_a.cfg_core_o, if_a.cfg_addr_o, if_a.cfg_data_o, busy_a, done_a,
                 p.core, p.addr, p.data);
      end
      @(negedge clk);
    end
    total++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || if_a.cfg_v_o !== 1'b0) begin
      bad++;
      $display("FAIL single_done: done=%b busy=%b v=%b, want done=1 busy=0 v=0", done_a, busy_a, if_a.cfg_v_o);
    end
  endtask

  task automatic test_four_core(input logic mode, input string tag);
    pkt_t p;
    int   got = 0;
    int   busy_err = 0;
    exp_q.delete();
    push_seq(4, 4, mode, 1'b0);
    mode_b = mode; en_b = 1'b0; rdy_b = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    total++;
    if (done_b !== 1'b0 || busy_b !== 1'b1) begin
      bad++;
      $display("FAIL %s_start: done=%b busy=%b, want done=0 busy=1", tag, done_b, busy_b);
    end
    for (int k = 0; k < 40 && done_b !== 1'b1; k++) begin
      if (busy_b !== 1'b1) busy_err++;
      if (if_b.cfg_v_o === 1'b1 && rdy_b) begin
        got++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s_extra_pkt: core=%0d addr=%h, want no packet", tag, if_b.cfg_core_o, if_b.cfg_addr_o);
        end else begin
          p = exp_q.pop_front();
          if (if_b.cfg_core_o !== 2'(p.core) || if_b.cfg_addr_o !== 16'(p.addr) || if_b.cfg_data_o !== p.data) begin
            bad++;
            $display("FAIL %s_pkt%0d: core=%0d addr=%h data=%h, want core=%0d addr=%h data=%h",
                     tag, got, if_b.cfg_core_o, if_b.cfg_addr_o, if_b.cfg_data_o, p.core, p.addr, p.data);
          end
        end
      end
      @(negedge clk);
    end
    total++;
    if (got != 16 || busy_err != 0 || done_b !== 1'b1 || busy_b !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_end: pkts=%0d busy_drops=%0d done=%b busy=%b left=%0d, want 16 0 1 0 0",
               tag, got, busy_err, done_b, busy_b, exp_q.size());
    end
  endtask

  task automatic test_ucode_rate();
    pkt_t p;
    int   got = 0;
    int   uc_cnt = 0;
    int   done_at = -1;
    exp_q.delete();
    push_seq(2, 4, 1'b0, 1'b1);
    mode_c = 1'b0; en_c = 1'b1; rdy_c = 1'b1; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int k = 1; k <= 60 && done_at < 0; k++) begin
      if (done_c === 1'b1) done_at = k;
      if (if_c.ucode_v_o === 1'b1) uc_cnt++;
      if (if_c.cfg_v_o === 1'b1 && rdy_c && exp_q.size() != 0) begin
        got++;
        p = exp_q.pop_front();
        total++;
        if (if_c.cfg_core_o !== 1'(p.core) || if_c.cfg_addr_o !== 16'(p.addr) || if_c.cfg_data_o !== p.data) begin
          bad++;
          $display("FAIL ucode_pkt%0d: core=%0d addr=%h data=%h, want core=%0d addr=%h data=%h",
                   got, if_c.cfg_core_o, if_c.cfg_addr_o, if_c.cfg_data_o, p.core, p.addr, p.data);
        end
      end
      @(negedge clk);
    end
    total++;
    if (uc_cnt != 8) begin
      bad++;
      $display("FAIL ucode_strobes: got %0d, want 8", uc_cnt);
    end
    // 6 cfg + 8 x 3-cycle ucode + 2 unfreeze packets, done one cycle later
    total++;
    if (done_at != 33 || got != 16) begin
      bad++;
      $display("FAIL ucode_timing: done at cycle %0d with %0d pkts, want cycle 33 with 16", done_at, got);
    end
  endtask

  task automatic test_stall_and_ignored_start();
    pkt_t        p;
    int          got = 0;
    logic        pv = 1'b0;
    logic [0:0]  pcore = '0;
    logic [15:0] paddr = '0;
    logic [63:0] pdata = '0;
    exp_q.delete();
    push_seq(2, 4, 1'b0, 1'b1);
    mode_c = 1'b0; en_c = 1'b1; rdy_c = 1'b0; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    mode_c = 1'b1; en_c = 1'b0;
    for (int k = 0; k < 400 && done_c !== 1'b1; k++) begin
      if (pv) begin
        total++;
        if (if_c.cfg_v_o !== 1'b1 || if_c.cfg_core_o !== pcore || if_c.cfg_addr_o !== paddr ||
            if_c.cfg_data_o !== pdata) begin
          bad++;
          $display("FAIL stall_hold: v=%b core=%0d addr=%h data=%h, want v=1 core=%0d addr=%h data=%h",
                   if_c.cfg_v_o, if_c.cfg_core_o, if_c.cfg_addr_o, if_c.cfg_data_o, pcore, paddr, pdata);
        end
      end
      rdy_c   = 1'($urandom_range(0, 1));
      start_c = (k == 20);
      if (if_c.cfg_v_o === 1'b1 && rdy_c) begin
        got++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stall_extra_pkt: addr=%h, want no packet", if_c.cfg_addr_o);
        end else begin
          p = exp_q.pop_front();
          if (if_c.cfg_core_o !== 1'(p.core) || if_c.cfg_addr_o !== 16'(p.addr) || if_c.cfg_data_o !== p.data) begin
            bad++;
            $display("FAIL stall_pkt%0d: core=%0d addr=%h data=%h, want core=%0d addr=%h data=%h",
                     got, if_c.cfg_core_o, if_c.cfg_addr_o, if_c.cfg_data_o, p.core, p.addr, p.data);
          end
        end
      end
      pv    = (if_c.cfg_v_o === 1'b1) && !rdy_c;
      pcore = if_c.cfg_core_o;
      paddr = if_c.cfg_addr_o;
      pdata = if_c.cfg_data_o;
      @(negedge clk);
    end
    start_c = 1'b0;
    total++;
    if (done_c !== 1'b1 || got != 16 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL stall_end: done=%b pkts=%0d left=%0d, want done=1 pkts=16 left=0", done_c, got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_ucode();
    pkt_t p;
    int   got = 0;
    int   seen = 0;
    mode_c = 1'b1; en_c = 1'b1; rdy_c = 1'b1; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      if (if_c.ucode_v_o === 1'b1) seen = 1;
      @(negedge clk);
    end
    total++;
    if (seen == 0) begin
      bad++;
      $display("FAIL rstmid_wait: ucode_v never seen, want strobe within 30 cycles");
    end
    rdy_c = 1'b0;
    @(negedge clk);
    total++;
    if (if_c.cfg_v_o !== 1'b1 || if_c.cfg_addr_o[15] !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_presend: v=%b addr=%h, want v=1 addr=8xxx", if_c.cfg_v_o, if_c.cfg_addr_o);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (if_c.cfg_v_o !== 1'b0 || if_c.cfg_addr_o !== '0 || if_c.cfg_data_o !== '0 || if_c.cfg_core_o !== '0 ||
        if_c.ucode_v_o !== 1'b0 || busy_c !== 1'b0 || done_c !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_outputs: v=%b addr=%h data=%h core=%0d uv=%b busy=%b done=%b, want all 0",
               if_c.cfg_v_o, if_c.cfg_addr_o, if_c.cfg_data_o, if_c.cfg_core_o, if_c.ucode_v_o, busy_c, done_c);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_c = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (if_c.cfg_v_o !== 1'b0 || busy_c !== 1'b0 || done_c !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_idle%0d: v=%b busy=%b done=%b, want 0 0 0", k, if_c.cfg_v_o, busy_c, done_c);
      end
    end
    exp_q.delete();
    push_seq(2, 4, 1'b1, 1'b1);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int k = 0; k < 400 && done_c !== 1'b1; k++) begin
      rdy_c = 1'($urandom_range(0, 1));
      if (if_c.cfg_v_o === 1'b1 && rdy_c && exp_q.size() != 0) begin
        got++;
        p = exp_q.pop_front();
        total++;
        if (if_c.cfg_core_o !== 1'(p.core) || if_c.cfg_addr_o !== 16'(p.addr) || if_c.cfg_data_o !== p.data) begin
          bad++;
          $display("FAIL rerun_pkt%0d: core=%0d addr=%h data=%h, want core=%0d addr=%h data=%h",
                   got, if_c.cfg_core_o, if_c.cfg_addr_o, if_c.cfg_data_o, p.core, p.addr, p.data);
        end
      end
      @(negedge clk);
    end
    total++;
    if (done_c !== 1'b1 || got != 16) begin
      bad++;
      $display("FAIL rerun_end: done=%b pkts=%0d, want done=1 pkts=16", done_c, got);
    end
  endtask

  initial begin
    test_reset();
    test_single_core_latency();
    test_four_core(1'b0, "four_core");
    test_four_core(1'b1, "rerun_from_done");
    test_ucode_rate();
    test_stall_and_ignored_start();
    test_reset_mid_ucode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
